// File: rtl/cam_stream_gen_if.sv
// Camera-side stream bundle: run/pattern controls in, VSYNC/HREF-framed RGB565 bytes and status out.
// HREF acts as the byte valid: DATA is meaningful only while HREF=1. There is no ready; the consumer must take one byte per clock.
interface cam_stream_gen_if;
  logic       ENABLE;
  logic [1:0] PATTERN;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] DATA;
  logic       FRAME_DONE;
  logic       BUSY;
  logic [7:0] FRAME_CNT;

  modport master (
    input  ENABLE, PATTERN,
    output VSYNC, HREF, DATA, FRAME_DONE, BUSY, FRAME_CNT
  );

  modport slave (
    output ENABLE, PATTERN,
    input  VSYNC, HREF, DATA, FRAME_DONE, BUSY, FRAME_CNT
  );
endinterface

// File: rtl/cam_stream_gen.sv
// Synthetic OV7670-style transmitter: VSYNC/VBP/LINE/BLANK/VFP framing of RGB565 test patterns, high byte first.
module cam_stream_gen #(
  parameter int H_ACTIVE  = 176,
  parameter int V_ACTIVE  = 144,
  parameter int H_BLANK   = 16,
  parameter int VSYNC_CYC = 1056,
  parameter int VBP_CYC   = 528,
  parameter int VFP_CYC   = 528
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  cam_stream_gen_if.master     bus,
  output logic [2:0]           state_dbg
);

  localparam int BYTES = 2 * H_ACTIVE;
  localparam int BW    = $clog2(BYTES);
  localparam int LW    = $clog2(V_ACTIVE + 1);
  localparam int PM0   = (VSYNC_CYC > VBP_CYC) ? VSYNC_CYC : VBP_CYC;
  localparam int PM1   = (VFP_CYC > H_BLANK) ? VFP_CYC : H_BLANK;
  localparam int PMAX  = (PM0 > PM1) ? PM0 : PM1;
  localparam int PW    = $clog2(PMAX + 1);
  localparam int BAR_W = H_ACTIVE >> 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VSYNC = 3'd1,
    S_VBP   = 3'd2,
    S_LINE  = 3'd3,
    S_BLANK = 3'd4,
    S_VFP   = 3'd5
  } state_t;

  state_t          state;
  logic [BW-1:0]   byte_cnt;
  logic [LW-1:0]   line_cnt;
  logic [PW-1:0]   porch_cnt;
  logic [1:0]      pat;
  logic            vsync, href, frame_done, busy;
  logic [7:0]      data, frame_cnt;

  // Outputs are registered, so the byte computed here is the one for the upcoming cycle.
  logic [BW-1:0]   nb;
  logic [LW-1:0]   ny;
  logic [15:0]     x16, bar, pix;
  logic [5:0]      y6;
  logic [7:0]      nbyte;

  always_comb begin
    nb  = '0;
    ny  = line_cnt;
    case (state)
      S_LINE:  nb = byte_cnt + BW'(1);
      S_BLANK: ny = line_cnt + LW'(1);
      default: ;
    endcase
    x16 = 16'(nb >> 1);
    y6  = 6'(ny);
    bar = '0;
    pix = '0;
    case (pat)
      2'd0: pix = 16'hF800;
      2'd1: pix = 16'h001F;
      2'd2: begin
        bar = x16 / 16'(BAR_W);
        if (bar > 16'd7) bar = 16'd7;
        case (bar[2:0])
          3'd0: pix = 16'hFFFF;
          3'd1: pix = 16'hFFE0;
          3'd2: pix = 16'h07FF;
          3'd3: pix = 16'h07E0;
          3'd4: pix = 16'hF81F;
          3'd5: pix = 16'hF800;
          3'd6: pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      default: pix = {x16[4:0], y6, 5'b0};
    endcase
    nbyte = nb[0] ? pix[7:0] : pix[15:8];
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      porch_cnt  <= '0;
      pat        <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ENABLE) begin
            state     <= S_VSYNC;
            vsync     <= 1'b1;
            busy      <= 1'b1;
            pat       <= bus.PATTERN;
            porch_cnt <= '0;
            line_cnt  <= '0;
          end
        end
        S_VSYNC: begin
          if (porch_cnt == PW'(VSYNC_CYC - 1)) begin
            state     <= S_VBP;
            vsync     <= 1'b0;
            porch_cnt <= '0;
          end else begin
            porch_cnt <= porch_cnt + PW'(1);
          end
        end
        S_VBP: begin
          if (porch_cnt == PW'(VBP_CYC - 1)) begin
            state     <= S_LINE;
            href      <= 1'b1;
            data      <= nbyte;
            byte_cnt  <= '0;
            porch_cnt <= '0;
          end else begin
            porch_cnt <= porch_cnt + PW'(1);
          end
        end
        S_LINE: begin
          if (byte_cnt == BW'(BYTES - 1)) begin
            state <= S_BLANK;
            href  <= 1'b0;
            data  <= '0;
          end else begin
            byte_cnt <= nb;
            data     <= nbyte;
          end
        end
        S_BLANK: begin
          if (porch_cnt == PW'(H_BLANK - 1)) begin
            porch_cnt <= '0;
            line_cnt  <= ny;
            if (ny == LW'(V_ACTIVE)) begin
              state      <= S_VFP;
              frame_done <= (VFP_CYC == 1);
            end else begin
              state    <= S_LINE;
              href     <= 1'b1;
              data     <= nbyte;
              byte_cnt <= '0;
            end
          end else begin
            porch_cnt <= porch_cnt + PW'(1);
          end
        end
        S_VFP: begin
          if (porch_cnt == PW'(VFP_CYC - 1)) begin
            porch_cnt <= '0;
            frame_cnt <= frame_cnt + 8'd1;
            // Back-to-back frames: VSYNC rises right after the FRAME_DONE cycle.
            if (bus.ENABLE) begin
              state    <= S_VSYNC;
              vsync    <= 1'b1;
              pat      <= bus.PATTERN;
              line_cnt <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            porch_cnt  <= porch_cnt + PW'(1);
            frame_done <= (porch_cnt == PW'(VFP_CYC - 2));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.VSYNC      = vsync;
  assign bus.HREF       = href;
  assign bus.DATA       = data;
  assign bus.FRAME_DONE = frame_done;
  assign bus.BUSY       = busy;
  assign bus.FRAME_CNT  = frame_cnt;
  assign state_dbg      = state;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen: small-config cycle maps, patterns, enable drop, reset abort, default-size frame period.
module tb_cam_stream_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cam_stream_gen_if sif ();
  cam_stream_gen_if bif ();
  logic [2:0] s_state, b_state;

  cam_stream_gen #(
    .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(4),
    .VSYNC_CYC(3), .VBP_CYC(2), .VFP_CYC(2)
  ) dut_s (
    .CLK(clk), .RESET_N(rst_n), .bus(sif.master), .state_dbg(s_state)
  );

  cam_stream_gen dut_b (
    .CLK(clk), .RESET_N(rst_n), .bus(bif.master), .state_dbg(b_state)
  );

  int checks = 0;
  int errors = 0;
  int exp_fc;
  logic [7:0] exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hand-written expectations for the small config (BAR_W = 1).
  function automatic logic [15:0] small_pix(input int pat, input int x, input int y);
    case (pat)
      0:       return 16'hF800;
      1:       return 16'h001F;
      default: return 16'((x << 11) | (y << 5));
    endcase
  endfunction

  task automatic push_frame(input int pat);
    logic [7:0] bars [16];
    logic [15:0] p;
    bars = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
             8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
    for (int y = 0; y < 2; y++) begin
      for (int b = 0; b < 16; b++) begin
        if (pat == 2) begin
          exp_q.push_back(bars[b]);
        end else begin
          p = small_pix(pat, b >> 1, y);
          exp_q.push_back((b % 2 == 1) ? p[7:0] : p[15:8]);
        end
      end
    end
  endtask

  // Entered with cycle 0 of a frame visible; leaves with cycle 47 visible.
  task automatic run_frame(input int pat, input bit cont, input int drop_at, input int pat_next);
    bit h;
    logic [7:0] eb;
    push_frame(pat);
    for (int c = 0; c < 48; c++) begin
      h  = (c >= 5 && c <= 20) || (c >= 25 && c <= 40);
      eb = 8'h00;
      if (h) eb = exp_q.pop_front();
      check($sformatf("p%0d vsync c%0d", pat, c), sif.VSYNC, (c <= 2) || (c == 47 && cont));
      check($sformatf("p%0d href c%0d", pat, c), sif.HREF, h);
      check($sformatf("p%0d data c%0d", pat, c), sif.DATA, eb);
      check($sformatf("p%0d frame_done c%0d", pat, c), sif.FRAME_DONE, c == 46);
      check($sformatf("p%0d busy c%0d", pat, c), sif.BUSY, (c < 47) || cont);
      check($sformatf("p%0d frame_cnt c%0d", pat, c), sif.FRAME_CNT, (c < 47) ? exp_fc : exp_fc + 1);
      if (c == 0) check("state vsync at c0", s_state, 3'd1);
      if (c == 47 && !cont) check("state idle after frame", s_state, 3'd0);
      if (c == 10) sif.PATTERN = 2'(pat_next);
      if (c == drop_at) sif.ENABLE = 1'b0;
      if (c < 47) tick();
    end
    exp_fc++;
    check("scoreboard drained", exp_q.size(), 0);
  endtask

  initial begin
    int vs_seen;
    int bad, href_cnt, fd_cycle, fd_count, period, first_href;
    logic prev_vs;
    logic [7:0] eb;

    rst_n = 1'b0;
    sif.ENABLE = 1'b0; sif.PATTERN = 2'd0;
    bif.ENABLE = 1'b0; bif.PATTERN = 2'd0;
    repeat (3) tick();
    check("reset vsync", sif.VSYNC, 0);
    check("reset href", sif.HREF, 0);
    check("reset data", sif.DATA, 0);
    check("reset frame_done", sif.FRAME_DONE, 0);
    check("reset busy", sif.BUSY, 0);
    check("reset frame_cnt", sif.FRAME_CNT, 0);
    check("reset state", s_state, 3'd0);

    rst_n = 1'b1;
    repeat (4) tick();
    check("idle busy", sif.BUSY, 0);
    check("idle vsync", sif.VSYNC, 0);

    // Scenarios 1-3 back to back; PATTERN is changed mid-frame each time.
    sif.ENABLE = 1'b1; sif.PATTERN = 2'd0;
    tick();
    exp_fc = 0;
    run_frame(0, 1'b1, -1, 2);
    run_frame(2, 1'b1, -1, 3);
    run_frame(3, 1'b0, 10, 1);

    vs_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sif.VSYNC || sif.BUSY) vs_seen++;
    end
    check("no restart after enable drop", vs_seen, 0);

    // Reset in the middle of LINE.
    sif.PATTERN = 2'd1; sif.ENABLE = 1'b1;
    tick();
    check("restart vsync", sif.VSYNC, 1);
    repeat (10) tick();
    check("byte5 href", sif.HREF, 1);
    check("byte5 data", sif.DATA, 8'h1F);
    check("byte5 state", s_state, 3'd3);
    rst_n = 1'b0;
    tick();
    check("abort vsync", sif.VSYNC, 0);
    check("abort href", sif.HREF, 0);
    check("abort data", sif.DATA, 0);
    check("abort frame_done", sif.FRAME_DONE, 0);
    check("abort busy", sif.BUSY, 0);
    check("abort frame_cnt", sif.FRAME_CNT, 0);
    rst_n = 1'b1;
    tick();
    check("post-reset busy", sif.BUSY, 1);
    exp_fc = 0;
    run_frame(1, 1'b0, 10, 1);

    // Default-size instance: period and pattern latching.
    bif.ENABLE = 1'b1; bif.PATTERN = 2'd0;
    tick();
    check("big vsync c0", bif.VSYNC, 1);
    check("big state c0", b_state, 3'd1);
    bad = 0; href_cnt = 0; fd_cycle = -1; fd_count = 0; period = -1; prev_vs = 1'b1;
    for (int c = 0; c < 60000; c++) begin
      if (c > 0 && bif.VSYNC && !prev_vs) begin
        period = c;
        break;
      end
      if (c == 20000) bif.PATTERN = 2'd1;
      if (bif.HREF) begin
        href_cnt++;
        eb = (href_cnt % 2 == 1) ? 8'hF8 : 8'h00;
        if (bif.DATA !== eb) bad++;
      end else if (bif.DATA !== 8'h00) begin
        bad++;
      end
      if (bif.FRAME_DONE) begin
        fd_cycle = c;
        fd_count++;
      end
      prev_vs = bif.VSYNC;
      tick();
    end
    check("big red frame bad bytes", bad, 0);
    check("big href bytes", href_cnt, 144 * 352);
    check("big frame_done cycle", fd_cycle, 55103);
    check("big frame_done pulses", fd_count, 1);
    check("big frame period", period, 55104);
    check("big frame_cnt", bif.FRAME_CNT, 1);

    first_href = -1;
    for (int c = 0; c < 2000; c++) begin
      if (bif.HREF) begin
        first_href = c;
        break;
      end
      tick();
    end
    check("big first href offset", first_href, 1584);
    bad = 0;
    for (int b = 0; b < 352; b++) begin
      eb = (b % 2 == 1) ? 8'h1F : 8'h00;
      if (bif.HREF !== 1'b1 || bif.DATA !== eb) bad++;
      tick();
    end
    check("big blue line bad bytes", bad, 0);
    bif.ENABLE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_stream_gen.md
# cam_stream_gen

- Synthetic OV7670-style camera transmitter.
- Emits VSYNC/HREF-framed RGB565 byte streams (two bytes per pixel, high byte first) with selectable test patterns.
- Drives the camera-side capture/downsample path on the bench and on hardware, where GPIO loopback replaces the real camera.
- Gives a deterministic, known-content frame source for checking the capture path, memory write addressing and VGA readback end to end.

## Interface

Parameters:
- H_ACTIVE, 176: active pixels per line; one line is 2*H_ACTIVE bytes.
- V_ACTIVE, 144: active lines per frame.
- H_BLANK, 16: HREF-low cycles after every active line.
- VSYNC_CYC, 1056: VSYNC-high cycles at frame start.
- VBP_CYC, 528: back-porch cycles between VSYNC fall and the first HREF.
- VFP_CYC, 528: front-porch cycles after the last line's blank.

Ports:
- CLK, input, 1: sole clock. All outputs change only on its rising edge.
- RESET_N, input, 1: synchronous, active-low reset.
- ENABLE, input, 1: run request. Sampled only in IDLE and at frame end.
- PATTERN, input, 2: pattern select, latched on entry to VSYNC and held for the whole frame.
- VSYNC, output, 1: frame sync, active high.
- HREF, output, 1: line valid, high during active bytes only.
- DATA, output, 8: pixel byte. Forced to 0 whenever HREF=0.
- FRAME_DONE, output, 1: one-cycle pulse on the last front-porch cycle.
- BUSY, output, 1: high in every state except IDLE.
- FRAME_CNT, output, 8: completed frames, wraps 255→0.

## Operation

- States: IDLE, VSYNC, VBP, LINE, BLANK, VFP.
- IDLE → VSYNC when ENABLE=1. Otherwise stay in IDLE.
- VSYNC: VSYNC=1 for VSYNC_CYC cycles, then → VBP.
- VBP: VBP_CYC cycles with VSYNC, HREF and DATA all 0, then → LINE with line=0.
- LINE: HREF=1 for 2*H_ACTIVE cycles, one byte per cycle.
  - Byte index b runs 0..2*H_ACTIVE-1. Pixel x=b>>1.
  - Even b carries pix[15:8], odd b carries pix[7:0].
  - After the last byte → BLANK.
- BLANK: H_BLANK cycles with HREF=0. Then increment line. If line==V_ACTIVE → VFP, else → LINE.
- VFP: VFP_CYC cycles. FRAME_DONE=1 on the last one, and FRAME_CNT increments on the same edge. Then → VSYNC if ENABLE=1, else → IDLE.
- Deasserting ENABLE mid-frame never truncates the frame. The current frame always completes.
- Patterns (pix is RGB565; x, y are the current pixel and line):
  - 0: solid red, 16'hF800.
  - 1: solid blue, 16'h001F.
  - 2: 8 vertical bars, each BAR_W=H_ACTIVE>>3 pixels wide. bar=x/BAR_W, clamped to 7.
    - Bar colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 3: gradient, pix={x[4:0], y[5:0], 5'b0}.
- Width rules:
  - Byte counter holds 2*H_ACTIVE-1.
  - Line counter holds V_ACTIVE.
  - Porch counter holds max(VSYNC_CYC, VBP_CYC, VFP_CYC, H_BLANK).
  - All parameters ≥1. H_ACTIVE ≥8.

## Timing

- Reset values (RESET_N=0 at a rising edge):
  - State IDLE.
  - VSYNC, HREF, DATA, FRAME_DONE and BUSY = 0.
  - FRAME_CNT=0.
  - All counters 0.
- Reset mid-frame aborts the frame immediately. FRAME_DONE does not pulse and FRAME_CNT is not incremented.
- Start latency: the first rising edge that samples RESET_N=1, ENABLE=1 in IDLE registers VSYNC=1 and BUSY=1.
- Frame length in cycles: VSYNC_CYC + VBP_CYC + V_ACTIVE*(2*H_ACTIVE+H_BLANK) + VFP_CYC.
- With ENABLE held high, consecutive frames have no gap. VSYNC rises on the cycle after FRAME_DONE.
- HREF and DATA change on the same edge. DATA is valid for the entire cycle HREF=1.
- A consumer samples on the following rising edge, or on the falling edge when using the inverted clock as PCLK.
- A PATTERN change mid-frame has no effect until the next VSYNC entry.

## Test plan

Small-parameter configuration used by scenarios 1–4: H_ACTIVE=8, V_ACTIVE=2, H_BLANK=4, VSYNC_CYC=3, VBP_CYC=2, VFP_CYC=2. Cycle 0 is the first VSYNC=1 cycle.

1. Small config, ENABLE=1, PATTERN=0 → required cycle map:
   - VSYNC=1 on cycles 0–2.
   - HREF=1 on cycles 5–20 and 25–40.
   - FRAME_DONE=1 on cycle 46 only; FRAME_CNT=1 from cycle 47.
   - VSYNC=1 again on cycle 47.
   - DATA alternates F8,00 during HREF and is 0 elsewhere.
2. Small config, PATTERN=2 → each line's bytes are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
3. Small config, PATTERN=3 → line 1, pixel 3 bytes are 18, 20. Line 0, pixel 7 bytes are 38, 00.
4. Small config, ENABLE dropped at cycle 10 → frame completes, FRAME_DONE at 46, then IDLE with BUSY=0 at 47. No VSYNC afterwards.
5. RESET_N=0 pulsed during LINE at byte 5, ENABLE=1 held → the next edge shows all outputs 0 and FRAME_CNT=0. After release, VSYNC=1 on the first edge sampling RESET_N=1, followed by a full frame.
6. Default parameters, PATTERN switched 0→1 mid-frame → the current frame stays red (F8,00). The next frame is blue (00,1F). The frame period is 1056+528+144*368+528 = 55104 cycles.
